rv32_exec_unit: RTL and testbench
=================================

RV32_EXEC_UNIT -- requirements
Module: rv32_exec_unit

Interface
REQ-001 SHALL have parameter RESET_INSTR, default 32'h00000013 (normalized NOP), instruction-register reset value.
REQ-002 SHALL have port iwClk  in  1  sole clock, rising edge.
REQ-003 SHALL have port iwRst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port iwInstrData  in  32  fetched instruction word at address iwPc.
REQ-005 SHALL have port iwPc  in  32  current program counter.
REQ-006 SHALL have ports iwReg1Data, iwReg2Data  in  32 each  register-file read data for owReadReg1/owReadReg2.
REQ-007 SHALL have port iwMemData  in  32  load data, already sub-word aligned and extended.
REQ-008 SHALL have ports owReadReg1, owReadReg2, owWriteReg  out  5 each  rs1, rs2, rd.
REQ-009 SHALL have ports owRegWrite  out  1  and owWriteRegValue  out  32  register write-back.
REQ-010 SHALL have ports owAluResult  out  32  (memory address) and owStoreData  out  32  (= iwReg2Data).
REQ-011 SHALL have ports owDMemSignExtend  out  1, owDMemAccess  out  2  (0 byte, 1 half, 2 word) and owWstrb  out  4.
REQ-012 SHALL have ports owNextPc  out  32, owPcUpdate  out  1  and orHalt  out  1.

Function
REQ-013 SHALL latch iwInstrData into the instruction register on each rising iwClk while not halted; decode is combinational from that register.
REQ-014 SHALL decode RV32I LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, LB/LH/LW/LBU/LHU, SB/SH/SW, OP-IMM, OP, FENCE (as NOP), ECALL, EBREAK.
REQ-015 SHALL classify each instruction into a 4-bit exception code: 0 success, 1 illegal, 2 ECALL, 3 EBREAK; any unlisted opcode/funct combination is illegal.
REQ-016 SHALL set orHalt on the first rising edge at which the exception code is non-zero; halt is sticky until reset.
REQ-017 SHALL force owRegWrite=0, owWstrb=0, owPcUpdate=0 while orHalt=1 or the current code is non-zero.
REQ-018 SHALL compute ALU A=iwReg1Data, B=iwReg2Data (OP, branches) or sign-extended I/S immediate; ops ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND; shift amount B[4:0]; all arithmetic mod 2^32.
REQ-019 SHALL derive zero=(result==0), branch taken = (~zero) XOR inverted; BEQ/BGE/BGEU inverted=1 using SUB/SLT/SLTU, BNE/BLT/BLTU inverted=0.
REQ-020 SHALL select owWriteRegValue: ALU result (OP, OP-IMM), iwMemData (loads), U-imm (LUI), iwPc+U-imm (AUIPC), iwPc+4 (JAL, JALR).
REQ-021 SHALL compute owNextPc: iwPc+4 default; iwPc+J-imm (JAL); (iwReg1Data+I-imm)&~1 (JALR); iwPc+B-imm if taken else iwPc+4 (branches).
REQ-022 SHALL drive owRegWrite=0 for branches, stores, FENCE, SYSTEM, and rd=x0 writes are allowed (register file discards).
REQ-023 SHALL drive owWstrb 4'b0001/4'b0011/4'b1111 for SB/SH/SW, 0 otherwise; owDMemSignExtend=1 for LB/LH/LW.

Reset
REQ-024 SHALL on iwRst load RESET_INSTR, clear orHalt, immediately and independent of clock, including mid-instruction.
REQ-025 SHALL after reset decode NOP: owRegWrite=1 to x0 with value 0, owNextPc=iwPc+4, owWstrb=0.

Structure
REQ-026 SHALL place ALU op codes, write-source, next-PC-source, memory-access and exception encodings in shared package rv32_exec_pkg.
REQ-027 SHALL contain one sub-module rv32_alu (combinational, result/zero/sign); decode and next-PC logic stay in the top.

Verification
REQ-028 ADDI x1,x0,5 (0x00500093) -> owWriteReg=1, owWriteRegValue=5, owRegWrite=1, owNextPc=iwPc+4.
REQ-029 BEQ with iwReg1Data=iwReg2Data=7, iwPc=0x100, offset +16 -> owNextPc=0x110; with 7 vs 8 -> 0x104.
REQ-030 JALR rs1=0x2001, imm=2, iwPc=0x40 -> owNextPc=0x2002, owWriteRegValue=0x44.
REQ-031 SRA 0x80000000 by 4 -> 0xF8000000; SLTU 1 vs 0xFFFFFFFF -> 1; SLT same -> 0.
REQ-032 ECALL 0x00000073 then 0xFFFFFFFF: orHalt=1 after edge, owRegWrite/owPcUpdate/owWstrb 0; assert iwRst -> orHalt=0, NOP decoded.

Source files
------------

// File: rtl/rv32_exec_pkg.sv
// rv32_exec_pkg: shared encodings for the RV32I execute unit.
package rv32_exec_pkg;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;
  typedef enum logic [2:0] {WB_ALU, WB_MEM, WB_IMM, WB_PC_IMM, WB_PC4} wb_src_e;
  typedef enum logic [1:0] {PC_PLUS4, PC_JAL, PC_JALR, PC_BRANCH} pc_src_e;
  typedef enum logic [1:0] {MEM_BYTE = 2'd0, MEM_HALF = 2'd1, MEM_WORD = 2'd2} mem_access_e;
  typedef enum logic [3:0] {
    EXC_NONE = 4'd0, EXC_ILLEGAL = 4'd1, EXC_ECALL = 4'd2, EXC_EBREAK = 4'd3
  } exc_e;
  localparam logic [6:0] OPC_LUI      = 7'h37;
  localparam logic [6:0] OPC_AUIPC    = 7'h17;
  localparam logic [6:0] OPC_JAL      = 7'h6f;
  localparam logic [6:0] OPC_JALR     = 7'h67;
  localparam logic [6:0] OPC_BRANCH   = 7'h63;
  localparam logic [6:0] OPC_LOAD     = 7'h03;
  localparam logic [6:0] OPC_STORE    = 7'h23;
  localparam logic [6:0] OPC_OP_IMM   = 7'h13;
  localparam logic [6:0] OPC_OP       = 7'h33;
  localparam logic [6:0] OPC_MISC_MEM = 7'h0f;
  localparam logic [6:0] OPC_SYSTEM   = 7'h73;
  function automatic alu_op_e alu_decode(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0: return alt ? ALU_SUB : ALU_ADD;
      3'd1: return ALU_SLL;
      3'd2: return ALU_SLT;
      3'd3: return ALU_SLTU;
      3'd4: return ALU_XOR;
      3'd5: return alt ? ALU_SRA : ALU_SRL;
      3'd6: return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/rv32_alu.sv
// rv32_alu: combinational RV32I integer ALU with zero and sign flags.
module rv32_alu
  import rv32_exec_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_e     op,
  output logic [31:0] result,
  output logic        zero,
  output logic        sign
);
  always_comb begin
    case (op)
      ALU_SUB:  result = a - b;
      ALU_SLL:  result = a << b[4:0];
      ALU_SLT:  result = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: result = {31'b0, a < b};
      ALU_XOR:  result = a ^ b;
      ALU_SRL:  result = a >> b[4:0];
      ALU_SRA:  result = $unsigned($signed(a) >>> b[4:0]);
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      default:  result = a + b;
    endcase
  end
  assign zero = result == 32'b0;
  assign sign = result[31];
endmodule

// File: rtl/rv32_exec_unit.sv
// rv32_exec_unit: single-cycle RV32I decode/execute stage with sticky halt on exceptions.
module rv32_exec_unit
  import rv32_exec_pkg::*;
#(
  parameter logic [31:0] RESET_INSTR = 32'h00000013
) (
  input  logic        iwClk,
  input  logic        iwRst,
  input  logic [31:0] iwInstrData,
  input  logic [31:0] iwPc,
  input  logic [31:0] iwReg1Data,
  input  logic [31:0] iwReg2Data,
  input  logic [31:0] iwMemData,
  output logic [4:0]  owReadReg1,
  output logic [4:0]  owReadReg2,
  output logic [4:0]  owWriteReg,
  output logic        owRegWrite,
  output logic [31:0] owWriteRegValue,
  output logic [31:0] owAluResult,
  output logic [31:0] owStoreData,
  output logic        owDMemSignExtend,
  output logic [1:0]  owDMemAccess,
  output logic [3:0]  owWstrb,
  output logic [31:0] owNextPc,
  output logic        owPcUpdate,
  output logic        orHalt
);
  logic [31:0] instr_q, instr_d, imm_i, imm_s, imm_b, imm_u, imm_j, alu_b, alu_result, pc4;
  logic        halt_q, halt_d, alu_zero, reg_write, sext, inverted, taken, kill;
  logic [6:0]  opcode, f7;
  logic [2:0]  f3;
  logic [1:0]  access;
  logic [3:0]  wstrb;
  alu_op_e     alu_op;
  wb_src_e     wb_src;
  pc_src_e     pc_src;
  exc_e        exc;
  assign opcode = instr_q[6:0];
  assign f3     = instr_q[14:12];
  assign f7     = instr_q[31:25];
  assign imm_i  = {{20{instr_q[31]}}, instr_q[31:20]};
  assign imm_s  = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
  assign imm_b  = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
  assign imm_u  = {instr_q[31:12], 12'b0};
  assign imm_j  = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};
  assign pc4    = iwPc + 32'd4;
  always_comb begin
    exc       = EXC_NONE;
    alu_op    = ALU_ADD;
    alu_b     = imm_i;
    wb_src    = WB_ALU;
    pc_src    = PC_PLUS4;
    reg_write = 1'b0;
    wstrb     = 4'b0000;
    sext      = 1'b0;
    access    = MEM_WORD;
    inverted  = 1'b0;
    case (opcode)
      OPC_LUI: begin
        reg_write = 1'b1;
        wb_src    = WB_IMM;
      end
      OPC_AUIPC: begin
        reg_write = 1'b1;
        wb_src    = WB_PC_IMM;
      end
      OPC_JAL: begin
        reg_write = 1'b1;
        wb_src    = WB_PC4;
        pc_src    = PC_JAL;
      end
      OPC_JALR: begin
        reg_write = 1'b1;
        wb_src    = WB_PC4;
        pc_src    = PC_JALR;
        exc       = f3 == 3'd0 ? EXC_NONE : EXC_ILLEGAL;
      end
      OPC_BRANCH: begin
        alu_b    = iwReg2Data;
        pc_src   = PC_BRANCH;
        // EQ/GE/GEU take the branch when the comparison result is zero
        alu_op   = f3[2] ? (f3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
        inverted = f3[2] ~^ f3[0];
        exc      = f3[2:1] == 2'b01 ? EXC_ILLEGAL : EXC_NONE;
      end
      OPC_LOAD: begin
        reg_write = 1'b1;
        wb_src    = WB_MEM;
        sext      = ~f3[2];
        access    = f3[1:0];
        exc       = (f3[1:0] == 2'b11 || f3[2:1] == 2'b11) ? EXC_ILLEGAL : EXC_NONE;
      end
      OPC_STORE: begin
        alu_b  = imm_s;
        access = f3[1:0];
        wstrb  = f3[1] ? 4'b1111 : f3[0] ? 4'b0011 : 4'b0001;
        exc    = (f3[2] || f3[1:0] == 2'b11) ? EXC_ILLEGAL : EXC_NONE;
      end
      OPC_OP_IMM: begin
        reg_write = 1'b1;
        alu_op    = alu_decode(f3, f3 == 3'd5 && f7[5]);
        exc       = ((f3 == 3'd1 && f7 != 7'd0) || (f3 == 3'd5 && {f7[6], f7[4:0]} != 6'd0))
                    ? EXC_ILLEGAL : EXC_NONE;
      end
      OPC_OP: begin
        reg_write = 1'b1;
        alu_b     = iwReg2Data;
        alu_op    = alu_decode(f3, f7[5]);
        exc       = (f7 == 7'd0 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) ? EXC_NONE : EXC_ILLEGAL;
      end
      OPC_MISC_MEM: exc = f3 == 3'd0 ? EXC_NONE : EXC_ILLEGAL;
      OPC_SYSTEM:   exc = instr_q == 32'h00000073 ? EXC_ECALL :
                          instr_q == 32'h00100073 ? EXC_EBREAK : EXC_ILLEGAL;
      default:      exc = EXC_ILLEGAL;
    endcase
  end
  rv32_alu u_alu (
    .a      (iwReg1Data),
    .b      (alu_b),
    .op     (alu_op),
    .result (alu_result),
    .zero   (alu_zero),
    .sign   ()
  );
  always_comb begin
    kill    = halt_q | (exc != EXC_NONE);
    taken   = ~alu_zero ^ inverted;
    instr_d = halt_q ? instr_q : iwInstrData;
    halt_d  = kill;
  end
  always_ff @(posedge iwClk or posedge iwRst) begin
    if (iwRst) begin
      instr_q <= RESET_INSTR;
      halt_q  <= 1'b0;
    end else begin
      instr_q <= instr_d;
      halt_q  <= halt_d;
    end
  end
  always_comb begin
    owReadReg1       = instr_q[19:15];
    owReadReg2       = instr_q[24:20];
    owWriteReg       = instr_q[11:7];
    owRegWrite       = reg_write & ~kill;
    owWstrb          = kill ? 4'b0000 : wstrb;
    owPcUpdate       = ~kill;
    orHalt           = halt_q;
    owAluResult      = alu_result;
    owStoreData      = iwReg2Data;
    owDMemSignExtend = sext;
    owDMemAccess     = access;
    owWriteRegValue  = wb_src == WB_MEM    ? iwMemData :
                       wb_src == WB_IMM    ? imm_u :
                       wb_src == WB_PC_IMM ? iwPc + imm_u :
                       wb_src == WB_PC4    ? pc4 : alu_result;
    owNextPc         = pc_src == PC_JAL  ? iwPc + imm_j :
                       pc_src == PC_JALR ? {alu_result[31:1], 1'b0} :
                       (pc_src == PC_BRANCH && taken) ? iwPc + imm_b : pc4;
  end
endmodule

// File: tb/tb_rv32_exec_unit.sv
// tb_rv32_exec_unit: scoreboard bench; random RV32I stimulus checked against an ISA-level model.
module tb_rv32_exec_unit;
  logic        iwClk, iwRst;
  logic [31:0] iwInstrData, iwPc, iwReg1Data, iwReg2Data, iwMemData;
  logic [4:0]  owReadReg1, owReadReg2, owWriteReg;
  logic        owRegWrite, owDMemSignExtend, owPcUpdate, orHalt;
  logic [31:0] owWriteRegValue, owAluResult, owStoreData, owNextPc;
  logic [1:0]  owDMemAccess;
  logic [3:0]  owWstrb;

  rv32_exec_unit dut (
    .iwClk(iwClk), .iwRst(iwRst), .iwInstrData(iwInstrData), .iwPc(iwPc),
    .iwReg1Data(iwReg1Data), .iwReg2Data(iwReg2Data), .iwMemData(iwMemData),
    .owReadReg1(owReadReg1), .owReadReg2(owReadReg2), .owWriteReg(owWriteReg),
    .owRegWrite(owRegWrite), .owWriteRegValue(owWriteRegValue), .owAluResult(owAluResult),
    .owStoreData(owStoreData), .owDMemSignExtend(owDMemSignExtend), .owDMemAccess(owDMemAccess),
    .owWstrb(owWstrb), .owNextPc(owNextPc), .owPcUpdate(owPcUpdate), .orHalt(orHalt)
  );

  initial iwClk = 1'b0;
  always #5 iwClk = ~iwClk;

  typedef struct {
    logic        halt, regw, pcu, chk_dec, chk_alu, chk_mem, sext, exc;
    logic [4:0]  rs1, rs2, wreg;
    logic [31:0] wval, npc, alu, sdata;
    logic [3:0]  wstrb;
    logic [1:0]  acc;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0, n_fail = 0;
  logic halted = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, want, $time);
    end
  endtask

  function automatic logic [31:0] arith(input logic [2:0] f3, input logic alt,
                                        input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0: return alt ? a - b : a + b;
      3'd1: return a << b[4:0];
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return alt ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  // ISA-level reference: what the architectural effects of one instruction should be
  function automatic exp_t model(input logic [31:0] i, input logic [31:0] pc, input logic [31:0] r1,
                                 input logic [31:0] r2, input logic [31:0] mem, input logic hlt);
    exp_t e;
    logic [31:0] immi, imms, immb, immu, immj;
    logic [2:0] f3;
    logic [6:0] f7;
    logic bad, sys, t;
    immi = {{20{i[31]}}, i[31:20]};
    imms = {{20{i[31]}}, i[31:25], i[11:7]};
    immb = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    immu = {i[31:12], 12'b0};
    immj = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    f3 = i[14:12];
    f7 = i[31:25];
    bad = 0; sys = 0; t = 0;
    e = '{default: 0};
    e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.wreg = i[11:7];
    e.npc = pc + 4; e.pcu = 1; e.chk_dec = 1; e.sdata = r2;
    case (i[6:0])
      7'h37: begin e.regw = 1; e.wval = immu; end
      7'h17: begin e.regw = 1; e.wval = pc + immu; end
      7'h6f: begin e.regw = 1; e.wval = pc + 4; e.npc = pc + immj; end
      7'h67: begin
        bad = f3 != 0; e.regw = 1; e.wval = pc + 4;
        e.npc = (r1 + immi) & ~32'd1; e.alu = r1 + immi; e.chk_alu = 1;
      end
      7'h63: begin
        case (f3)
          3'd0: t = r1 == r2;
          3'd1: t = r1 != r2;
          3'd4: t = $signed(r1) < $signed(r2);
          3'd5: t = $signed(r1) >= $signed(r2);
          3'd6: t = r1 < r2;
          3'd7: t = r1 >= r2;
          default: bad = 1;
        endcase
        e.npc = t ? pc + immb : pc + 4;
      end
      7'h03: begin
        bad = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        e.regw = 1; e.wval = mem; e.alu = r1 + immi; e.chk_alu = 1;
        e.chk_mem = 1; e.acc = f3[1:0]; e.sext = f3 < 3;
      end
      7'h23: begin
        bad = f3 > 2;
        e.wstrb = f3 == 0 ? 4'h1 : f3 == 1 ? 4'h3 : 4'hf;
        e.alu = r1 + imms; e.chk_alu = 1; e.chk_mem = 1; e.acc = f3[1:0];
      end
      7'h13: begin
        bad = (f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 7'h20);
        e.regw = 1; e.wval = arith(f3, f3 == 5 && f7 == 7'h20, r1, immi);
        e.alu = e.wval; e.chk_alu = 1;
      end
      7'h33: begin
        bad = !(f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)));
        e.regw = 1; e.wval = arith(f3, f7 == 7'h20, r1, r2);
        e.alu = e.wval; e.chk_alu = 1;
      end
      7'h0f: bad = f3 != 0;
      7'h73: if (i == 32'h00000073 || i == 32'h00100073) sys = 1; else bad = 1;
      default: bad = 1;
    endcase
    e.exc = bad | sys;
    if (e.exc || hlt) begin
      e.regw = 0; e.wstrb = 0; e.pcu = 0; e.chk_alu = 0; e.chk_mem = 0;
    end
    if (hlt) begin
      e.halt = 1; e.chk_dec = 0;
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hffff_ffff;
      3: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [2:0] f3;
    logic [6:0] f7;
    r = $urandom;
    f3 = r[14:12];
    case ($urandom_range(0, 9))
      0: return {r[31:7], 7'h37};
      1: return {r[31:7], 7'h17};
      2: return {r[31:7], 7'h6f};
      3: return {r[31:15], 3'd0, r[11:7], 7'h67};
      4: begin
        f3 = 3'($urandom_range(0, 5));
        f3 = f3 < 2 ? f3 : f3 + 3'd2;
        return {r[31:15], f3, r[11:7], 7'h63};
      end
      5: begin
        f3 = 3'($urandom_range(0, 4));
        f3 = f3 < 3 ? f3 : f3 + 3'd1;
        return {r[31:15], f3, r[11:7], 7'h03};
      end
      6: return {r[31:15], 3'($urandom_range(0, 2)), r[11:7], 7'h23};
      7: begin
        f7 = f3 == 1 ? 7'h00 : f3 == 5 ? (r[30] ? 7'h20 : 7'h00) : r[31:25];
        return {f7, r[24:15], f3, r[11:7], 7'h13};
      end
      8: begin
        f7 = ((f3 == 0 || f3 == 5) && r[30]) ? 7'h20 : 7'h00;
        return {f7, r[24:15], f3, r[11:7], 7'h33};
      end
      default: return {r[31:15], 3'd0, r[11:7], 7'h0f};
    endcase
  endfunction

  task automatic issue(input logic [31:0] i, input logic [31:0] pc, input logic [31:0] r1,
                       input logic [31:0] r2, input logic [31:0] mem, input logic ovr = 1'b0,
                       input logic [31:0] wv = 32'h0, input logic [31:0] np = 32'h0);
    exp_t e;
    iwInstrData = i;
    @(posedge iwClk);
    #1;
    iwPc = pc; iwReg1Data = r1; iwReg2Data = r2; iwMemData = mem;
    e = model(i, pc, r1, r2, mem, halted);
    if (ovr) begin
      e.wval = wv; e.npc = np;
    end
    if (e.exc) halted = 1'b1;
    sb.push_back(e);
  endtask

  task automatic reset_check(input logic [31:0] pc);
    @(negedge iwClk);
    #2;
    iwPc = pc; iwReg1Data = 32'h0; iwInstrData = 32'h00000013;
    iwRst = 1'b1;
    #1;
    chk("rst_halt", 32'(orHalt), 32'd0);
    chk("rst_regw", 32'(owRegWrite), 32'd1);
    chk("rst_rd", 32'(owWriteReg), 32'd0);
    chk("rst_wval", owWriteRegValue, 32'd0);
    chk("rst_npc", owNextPc, pc + 32'd4);
    chk("rst_wstrb", 32'(owWstrb), 32'd0);
    chk("rst_pcu", 32'(owPcUpdate), 32'd1);
    #1;
    iwRst = 1'b0;
    halted = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge iwClk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("halt", 32'(orHalt), 32'(e.halt));
        chk("regw", 32'(owRegWrite), 32'(e.regw));
        chk("pcu", 32'(owPcUpdate), 32'(e.pcu));
        chk("wstrb", 32'(owWstrb), 32'(e.wstrb));
        if (e.chk_dec) begin
          chk("rs1", 32'(owReadReg1), 32'(e.rs1));
          chk("rs2", 32'(owReadReg2), 32'(e.rs2));
        end
        if (e.regw) begin
          chk("rd", 32'(owWriteReg), 32'(e.wreg));
          chk("wval", owWriteRegValue, e.wval);
        end
        if (e.pcu) chk("npc", owNextPc, e.npc);
        if (e.chk_alu) chk("alu", owAluResult, e.alu);
        if (e.chk_mem) begin
          chk("acc", 32'(owDMemAccess), 32'(e.acc));
          chk("sext", 32'(owDMemSignExtend), 32'(e.sext));
          if (e.wstrb != 0) chk("sdata", owStoreData, e.sdata);
        end
      end
    end
  end

  logic [31:0] bad_list [3] = '{32'h00100073, 32'h022081B3, 32'h00002063};

  initial begin : stim
    logic [31:0] r1, pc;
    iwRst = 1'b1;
    iwInstrData = 32'h0; iwPc = 32'h200; iwReg1Data = 32'h0; iwReg2Data = 32'h0; iwMemData = 32'h0;
    repeat (2) @(posedge iwClk);
    #3;
    chk("init_halt", 32'(orHalt), 32'd0);
    chk("init_regw", 32'(owRegWrite), 32'd1);
    chk("init_rd", 32'(owWriteReg), 32'd0);
    chk("init_wval", owWriteRegValue, 32'd0);
    chk("init_npc", owNextPc, 32'h204);
    chk("init_wstrb", 32'(owWstrb), 32'd0);
    iwRst = 1'b0;
    issue(32'h00500093, 32'h300, 32'h0, 32'h0, 32'h0, 1'b1, 32'd5, 32'h304);
    issue(32'h00208863, 32'h100, 32'd7, 32'd7, 32'h0, 1'b1, 32'h0, 32'h110);
    issue(32'h00208863, 32'h100, 32'd7, 32'd8, 32'h0, 1'b1, 32'h0, 32'h104);
    issue(32'h002100E7, 32'h40, 32'h2001, 32'h0, 32'h0, 1'b1, 32'h44, 32'h2002);
    issue(32'h4020D1B3, 32'h80, 32'h8000_0000, 32'd4, 32'h0, 1'b1, 32'hF800_0000, 32'h84);
    issue(32'h0020B1B3, 32'h84, 32'd1, 32'hffff_ffff, 32'h0, 1'b1, 32'd1, 32'h88);
    issue(32'h0020A1B3, 32'h88, 32'd1, 32'hffff_ffff, 32'h0, 1'b1, 32'd0, 32'h8c);
    for (int k = 0; k < 400; k++) begin
      r1 = rand_word();
      pc = {$urandom_range(0, 32'h3fff_ffff), 2'b00};
      issue(rand_instr(), pc, r1, ($urandom_range(0, 3) == 0) ? r1 : rand_word(), $urandom);
    end
    issue(32'h00000073, 32'h500, 32'h1, 32'h2, 32'h0);
    issue(32'hFFFFFFFF, 32'h504, 32'h1, 32'h2, 32'h0);
    issue(32'h00500093, 32'h508, 32'h0, 32'h0, 32'h0);
    reset_check(32'h600);
    for (int k = 0; k < 3; k++) begin
      issue(bad_list[k], 32'h700, $urandom, $urandom, $urandom);
      issue(32'h00500093, 32'h704, 32'h0, 32'h0, 32'h0);
      reset_check(32'h800 + 32'(k * 16));
    end
    issue(32'h00500093, 32'h900, 32'h0, 32'h0, 32'h0, 1'b1, 32'd5, 32'h904);
    repeat (3) @(negedge iwClk);
    #1;
    chk("drain", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
